credbasedfc_rx_44: RTL and testbench
====================================

// Module: credbasedfc_rx_44
// PURPOSE
//  Receiver end of the 4-stage credit-based flow-control link.
//  - Accepts words on down_data/down_valid. There is no ready: the sender may send only when it holds a credit.
//  - Buffers the words in a DEPTH-entry FIFO and presents them to the local consumer with a valid/ready handshake.
//  - Returns one down_credit pulse per word the consumer drains.
//  - Publishes the credit_initval the sender loads at reset.
// PARAMETERS
//  D_WIDTH       6  data word width; must match the sender
//  CREDIT_WIDTH  3  sender credit counter width; DEPTH must be <= 2**CREDIT_WIDTH-1
//  DEPTH         4  FIFO entries, which is also the number of credits granted
// PORTS
//  clk             in   1             clock; all logic on posedge
//  rst             in   1             synchronous reset, active-high
//  down_data       in   D_WIDTH       word from the sender pipeline
//  down_valid      in   1             down_data is valid this cycle
//  down_credit     out  1             one-cycle pulse that returns one credit to the sender
//  credit_initval  out  CREDIT_WIDTH  constant DEPTH; wired to the sender's credit_initval
//  out_data        out  D_WIDTH       FIFO head word
//  out_valid       out  1             FIFO is non-empty
//  out_ready       in   1             consumer accepts out_data
//  overflow        out  1             sticky overflow error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - wr_ptr, rd_ptr and count go to 0.
//   - out_valid=0, down_credit=0, overflow=0.
//   - out_data is don't-care while out_valid=0.
//   - FIFO storage is not reset.
//   - Reset asserted mid-operation discards all buffered words and emits no credits for them. Sender and receiver share rst.
//  Storage:
//   - Circular buffer; wr_ptr and rd_ptr are $clog2(DEPTH) bits each.
//   - Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
//   - count is $clog2(DEPTH+1) bits, range 0..DEPTH.
//  Push:
//   - push = down_valid & (count<DEPTH | pop).
//   - The word is written at wr_ptr on that posedge.
//  Pop:
//   - pop = out_valid & out_ready.
//   - rd_ptr advances on that posedge.
//  Count update:
//   - push only: count+1.
//   - pop only: count-1.
//   - push and pop together: count unchanged. This holds at full (the head is read out while the new word lands in the freed slot) and at empty+1.
//  Output:
//   - out_valid = (count!=0).
//   - out_data = mem[rd_ptr] (show-ahead).
//   - A word pushed at posedge N is visible on out_data/out_valid after posedge N, i.e. 1-cycle latency. There is no bypass when empty.
//  Credit return:
//   - down_credit is registered and equals pop delayed by one cycle.
//   - Exactly one pulse per popped word; back-to-back pops give back-to-back pulses.
//   - The sender's four credit delay stages make the credit round trip 5 cycles from pop to the sender counter increment.
//  Invariant:
//   - count + credits held by the sender + credits in flight == DEPTH at every cycle boundary after reset.
//  Drop rule:
//   - A word that arrives with down_valid=1, count==DEPTH and no pop is dropped.
//   - FIFO contents and pointers stay unchanged; data is never overwritten.
//   - This is a protocol violation by the sender.
// CONFIGURATION
//  CREDBASEDFC_RX_OVF_CHECK_EN
//   - Defined:
//     - overflow is set on the posedge after a dropped word and holds until rst.
//     - A simulation-only assertion fires on every dropped word.
//   - Undefined:
//     - overflow is tied to 1'b0.
//     - The detection logic and assertion are not compiled.
//     - The drop rule still applies.
// TESTING
//  T1 reset:
//   - Stimulus: rst=1 for 2 cycles.
//   - Required: out_valid=0, down_credit=0, overflow=0, credit_initval=3'd4.
//  T2 single word:
//   - Stimulus: down_valid=1, down_data=6'h2A for 1 cycle, out_ready=1.
//   - Required: out_valid=1 with out_data=6'h2A on the next cycle; down_credit pulses for 1 cycle one cycle after the pop.
//  T3 fill/drain:
//   - Stimulus: push 6'h01..6'h04 back-to-back with out_ready=0.
//   - Required: count=4 and no credits.
//   - Stimulus: then hold out_ready=1.
//   - Required: words pop in order 01,02,03,04; down_credit is high 4 consecutive cycles; out_valid=0 afterwards.
//  T4 full with simultaneous push+pop:
//   - Stimulus: FIFO full with 10..13; push 6'h14 while out_ready=1.
//   - Required: 10 pops, 14 is stored, count stays 4, one credit pulse.
//  T5 overflow (macro defined):
//   - Stimulus: FIFO full, out_ready=0, push 6'h3F.
//   - Required: overflow=1 and held; contents still 10..13 in order.
//   - Macro undefined: overflow stays 0 and the same contents hold.
//  T6 loopback with credbasedfc_44, credit_initval connected:
//   - Stimulus: 200 random up_valid/out_ready cycles.
//   - Required: output sequence equals input sequence; overflow never set; the credit invariant holds every cycle.

Source files
------------

// File: rtl/credbasedfc_rx_44.sv
// Receiver end of a credit-based flow-control link: DEPTH-entry show-ahead FIFO, one credit per drained word.
// Optional sticky overflow detection is compiled in when CREDBASEDFC_RX_OVF_CHECK_EN is defined.
module credbasedfc_rx_44 #(
  parameter int D_WIDTH      = 6,
  parameter int CREDIT_WIDTH = 3,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [D_WIDTH-1:0]      down_data,
  input  logic                    down_valid,
  output logic                    down_credit,
  output logic [CREDIT_WIDTH-1:0] credit_initval,
  output logic [D_WIDTH-1:0]      out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               credit_q, credit_d;
  logic               full, push, pop;

  assign credit_initval = CREDIT_WIDTH'(DEPTH);
  assign full           = (count_q == CW'(DEPTH));
  assign out_valid      = (count_q != '0);
  assign out_data       = mem_q[rd_ptr_q];
  assign pop            = out_valid & out_ready;
  // At full a simultaneous pop frees the head slot, so the incoming word is still accepted.
  assign push           = down_valid & (~full | pop);
  assign down_credit    = credit_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = pop;
    if (push) begin
      mem_d[wr_ptr_q] = down_data;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Storage carries no reset; out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef CREDBASEDFC_RX_OVF_CHECK_EN
  logic drop, ovf_q, ovf_d;
  assign drop     = down_valid & full & ~pop;
  assign ovf_d    = ovf_q | drop;
  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  // synthesis-irrelevant sanity check: sender must never send without a credit
  a_no_drop: assert property (@(posedge clk) disable iff (rst) !drop)
    else $error("credbasedfc_rx_44: word dropped, sender exceeded its credits");
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_credbasedfc_rx_44.sv
// Directed vector table plus a credit-loopback run against a small sender model.
module tb_credbasedfc_rx_44;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] down_data;
  logic       down_valid;
  logic       down_credit;
  logic [2:0] credit_initval;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  credbasedfc_rx_44 #(.D_WIDTH(6), .CREDIT_WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .down_data(down_data), .down_valid(down_valid),
    .down_credit(down_credit), .credit_initval(credit_initval),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    logic [5:0] dd;
    logic       ordy;
    logic       ev;   // expected out_valid after the edge
    logic [5:0] ed;   // expected out_data (checked only when ev)
    logic       ec;   // expected down_credit
    logic       eo;   // expected overflow when the check is compiled in
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic r, input logic dv, input logic [5:0] dd, input logic ordy,
                      input logic ev, input logic [5:0] ed, input logic ec, input logic eo);
    vec_t v;
    v.rst = r; v.dv = dv; v.dd = dd; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
    vq.push_back(v);
  endtask

  // loopback sender model state
  int         credits;
  logic [3:0] dly;
  logic [5:0] sbq[$];
  logic       snd, popping;
  int         inflight;

  initial begin
    rst = 1'b1; down_valid = 1'b0; down_data = '0; out_ready = 1'b0;

    //   rst dv  dd    rdy  ev  ed    ec  eo
    addv(1, 0, 6'h00, 0,   0, 6'h00, 0, 0);  // T1 reset
    addv(1, 0, 6'h00, 0,   0, 6'h00, 0, 0);
    addv(0, 1, 6'h2A, 1,   1, 6'h2A, 0, 0);  // T2 single word, 1-cycle latency
    addv(0, 0, 6'h00, 1,   0, 6'h00, 1, 0);  // popped -> credit next cycle
    addv(0, 0, 6'h00, 1,   0, 6'h00, 0, 0);
    addv(0, 1, 6'h01, 0,   1, 6'h01, 0, 0);  // T3 fill
    addv(0, 1, 6'h02, 0,   1, 6'h01, 0, 0);
    addv(0, 1, 6'h03, 0,   1, 6'h01, 0, 0);
    addv(0, 1, 6'h04, 0,   1, 6'h01, 0, 0);
    addv(0, 0, 6'h00, 1,   1, 6'h02, 1, 0);  // drain, 4 back-to-back credits
    addv(0, 0, 6'h00, 1,   1, 6'h03, 1, 0);
    addv(0, 0, 6'h00, 1,   1, 6'h04, 1, 0);
    addv(0, 0, 6'h00, 1,   0, 6'h00, 1, 0);
    addv(0, 0, 6'h00, 1,   0, 6'h00, 0, 0);
    addv(0, 1, 6'h10, 0,   1, 6'h10, 0, 0);  // fill 10..13
    addv(0, 1, 6'h11, 0,   1, 6'h10, 0, 0);
    addv(0, 1, 6'h12, 0,   1, 6'h10, 0, 0);
    addv(0, 1, 6'h13, 0,   1, 6'h10, 0, 0);
    addv(0, 1, 6'h3F, 0,   1, 6'h10, 0, 1);  // T5 push into full FIFO is dropped
    addv(0, 0, 6'h00, 0,   1, 6'h10, 0, 1);  // overflow sticky
    addv(0, 1, 6'h14, 1,   1, 6'h11, 1, 1);  // T4 push+pop at full
    addv(0, 0, 6'h00, 0,   1, 6'h11, 0, 1);  // exactly one credit pulse
    addv(0, 0, 6'h00, 1,   1, 6'h12, 1, 1);
    addv(0, 0, 6'h00, 1,   1, 6'h13, 1, 1);
    addv(0, 0, 6'h00, 1,   1, 6'h14, 1, 1);  // 3F never stored
    addv(0, 0, 6'h00, 1,   0, 6'h00, 1, 1);
    addv(0, 0, 6'h00, 0,   0, 6'h00, 0, 1);
    addv(0, 1, 6'h05, 0,   1, 6'h05, 0, 1);  // reset mid-operation
    addv(1, 0, 6'h00, 1,   0, 6'h00, 0, 0);
    addv(0, 0, 6'h00, 1,   0, 6'h00, 0, 0);  // no credit for discarded word
    addv(0, 1, 6'h06, 0,   1, 6'h06, 0, 0);  // push+pop at count 1
    addv(0, 1, 6'h07, 1,   1, 6'h07, 1, 0);
    addv(0, 0, 6'h00, 1,   0, 6'h00, 1, 0);
    addv(0, 0, 6'h00, 1,   0, 6'h00, 0, 0);

    foreach (vq[i]) begin
      logic eo;
      @(negedge clk);
      rst = vq[i].rst; down_valid = vq[i].dv; down_data = vq[i].dd; out_ready = vq[i].ordy;
      @(posedge clk); #1;
`ifdef CREDBASEDFC_RX_OVF_CHECK_EN
      eo = vq[i].eo;
`else
      eo = 1'b0;
`endif
      chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(vq[i].ev));
      if (vq[i].ev) chk($sformatf("v%0d out_data", i), int'(out_data), int'(vq[i].ed));
      chk($sformatf("v%0d down_credit", i), int'(down_credit), int'(vq[i].ec));
      chk($sformatf("v%0d overflow", i), int'(overflow), int'(eo));
      if (i == 0) chk("credit_initval", int'(credit_initval), 4);
    end

    // T6 loopback: sender with 4 credit delay stages, random traffic
    @(negedge clk);
    rst = 1'b1; down_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    credits = 4; dly = '0; sbq.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      snd       = ($urandom_range(0, 1) == 1) && (credits > 0);
      down_valid = snd;
      down_data = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 2) != 0);
      popping   = out_valid && out_ready;
      if (popping) begin
        if (sbq.size() == 0) chk("t6 spurious out_valid", 1, 0);
        else chk($sformatf("t6 c%0d out_data", c), int'(out_data), int'(sbq.pop_front()));
      end
      if (snd) sbq.push_back(down_data);
      credits = credits - int'(snd) + int'(dly[3]);
      dly = {dly[2:0], down_credit};
      @(posedge clk); #1;
      inflight = int'(dly[0]) + int'(dly[1]) + int'(dly[2]) + int'(dly[3]) + int'(down_credit);
      chk($sformatf("t6 c%0d invariant", c), sbq.size() + credits + inflight, 4);
      chk($sformatf("t6 c%0d out_valid", c), int'(out_valid), int'(sbq.size() != 0));
      chk($sformatf("t6 c%0d overflow", c), int'(overflow), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
